gray_gauss3x3: RTL and testbench

- 3x3 Gaussian smoothing stage placed directly downstream of the RGB565-to-gray converter in the edge-detection pipeline.
- Consumes the 8-bit gray pixel stream with vld/sop/eop framing.
- Uses two line buffers to build a 3x3 window and emits the smoothed pixel with the same framing signals.
- Feeds the Sobel/edge stage. The output image is the valid interior only, (IMG_H-2) x (IMG_W-2).

---
 rtl/gray_gauss3x3_if.sv | 24 ++
 rtl/gray_gauss3x3.sv | 151 +++++++++++++++
 tb/tb_gray_gauss3x3.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_gauss3x3_if.sv
// Gray pixel stream interface for the 3x3 Gaussian smoothing stage.
// Carries the input stream (din/vld/sop/eop) and the smoothed output
// stream (dout/vld/sop/eop). The master side drives pixels in and
// receives results; the slave side is the filter itself.
interface gray_gauss3x3_if;
    logic [7:0] din;
    logic       din_vld;
    logic       din_sop;
    logic       din_eop;
    logic [7:0] dout;
    logic       dout_vld;
    logic       dout_sop;
    logic       dout_eop;

    modport master (
        output din, din_vld, din_sop, din_eop,
        input  dout, dout_vld, dout_sop, dout_eop
    );

    modport slave (
        input  din, din_vld, din_sop, din_eop,
        output dout, dout_vld, dout_sop, dout_eop
    );
endinterface

// File: rtl/gray_gauss3x3.sv
// 3x3 Gaussian smoothing of an 8-bit gray stream.
// Two line buffers plus two column registers form the 3x3 window; the
// newest window column comes straight from the line-buffer reads and din.
// Output image is the valid interior only, (IMG_H-2) x (IMG_W-2), two clocks
// after the accepted input pixel that completes each window.
module gray_gauss3x3 #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input logic              clk,
    input logic              rst,
    gray_gauss3x3_if.slave   px
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    // Kernel [1 2 1; 2 4 2; 1 2 1]; each column packed {row r-2, row r-1, row r}.
    function automatic logic [11:0] gauss_sum(input logic [23:0] cl,
                                              input logic [23:0] cm,
                                              input logic [23:0] cr);
        logic [11:0] s;
        s = {4'b0, cl[23:16]}       + {3'b0, cl[15:8], 1'b0} + {4'b0, cl[7:0]}
          + {3'b0, cm[23:16], 1'b0} + {2'b0, cm[15:8], 2'b0} + {3'b0, cm[7:0], 1'b0}
          + {4'b0, cr[23:16]}       + {3'b0, cr[15:8], 1'b0} + {4'b0, cr[7:0]};
        return s;
    endfunction

    // Divide by the kernel weight 16 by truncation; max sum 4080 fits 8 bits.
    function automatic logic [7:0] trunc_pix(input logic [11:0] s);
        return 8'(s >> 4);
    endfunction

    // Frame position and framing state
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic          armed;

    // Line buffers: lb1 holds row r-1, lb2 holds row r-2
    logic [7:0]    lb1 [0:IMG_W-1];
    logic [7:0]    lb2 [0:IMG_W-1];
    logic [7:0]    lb1_rd;
    logic [7:0]    lb2_rd;

    // Window columns c-2 and c-1
    logic [23:0]   win_c2;
    logic [23:0]   win_c1;
    logic [23:0]   win_new;
    logic          win_ok;
    logic [11:0]   sum_nxt;

    // Pipeline registers
    logic [11:0]   sum_p1;
    logic          vld_p1;
    logic          sop_p1;
    logic          eop_p1;
    logic [7:0]    dout_p2;
    logic          vld_p2;
    logic          sop_p2;
    logic          eop_p2;

    // Current pixel position, line-buffer reads and window-valid decode
    always_comb begin
        cur_col = px.din_sop ? '0 : col;
        cur_row = px.din_sop ? '0 : row;
        lb1_rd  = lb1[cur_col];
        lb2_rd  = lb2[cur_col];
        win_new = {lb2_rd, lb1_rd, px.din};
        sum_nxt = gauss_sum(win_c2, win_c1, win_new);
        // Outputs are suppressed after reset until a frame start is seen.
        win_ok  = px.din_vld && (armed || px.din_sop)
                  && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
    end

    // Row/column counters advance only on accepted pixels
    always_ff @(posedge clk) begin
        if (rst) begin
            col   <= '0;
            row   <= '0;
            armed <= 1'b0;
        end else if (px.din_vld) begin
            if (px.din_sop) begin
                armed <= 1'b1;
            end
            if (px.din_eop || (cur_row == ROW_LAST && cur_col == COL_LAST)) begin
                col <= '0;
                row <= '0;
            end else if (cur_col == COL_LAST) begin
                col <= '0;
                row <= cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end
    end

    // Line buffers (read-before-write) and window shift; contents never reset
    always_ff @(posedge clk) begin
        if (px.din_vld) begin
            lb2[cur_col] <= lb1_rd;
            lb1[cur_col] <= px.din;
            win_c2       <= win_c1;
            win_c1       <= win_new;
        end
    end

    // ---- stage 1: window sum ----
    always_ff @(posedge clk) begin
        sum_p1 <= sum_nxt;
        if (rst) begin
            vld_p1 <= 1'b0;
            sop_p1 <= 1'b0;
            eop_p1 <= 1'b0;
        end else begin
            vld_p1 <= win_ok;
            sop_p1 <= win_ok && (cur_row == ROW_TWO) && (cur_col == COL_TWO);
            eop_p1 <= win_ok && px.din_eop;
        end
    end

    // ---- stage 2: output register, dout holds between valid beats ----
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_p2 <= '0;
            vld_p2  <= 1'b0;
            sop_p2  <= 1'b0;
            eop_p2  <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            sop_p2 <= sop_p1;
            eop_p2 <= eop_p1;
            if (vld_p1) begin
                dout_p2 <= trunc_pix(sum_p1);
            end
        end
    end

    assign px.dout     = dout_p2;
    assign px.dout_vld = vld_p2;
    assign px.dout_sop = sop_p2;
    assign px.dout_eop = eop_p2;

endmodule

// File: tb/tb_gray_gauss3x3.sv
// Bench for gray_gauss3x3 on an 8x6 image: directed frames, a table of
// hand-computed output pixels, and hand-written restart/reset sequences.
module tb_gray_gauss3x3;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int OW = W - 2;
    localparam int NP = W * H;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gray_gauss3x3_if bus();

    gray_gauss3x3 #(.IMG_W(W), .IMG_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .px  (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        int         edge_no;
    } beat_t;

    typedef struct {
        int test;
        int r;
        int c;
        int exp;
    } vec_t;

    beat_t got_q[$];
    beat_t exp_q[$];
    vec_t  vecs[$];

    int errors  = 0;
    int checks  = 0;
    int edge_n  = 0;
    int last_in_edge = 0;
    bit mon_en  = 1'b0;
    int img     [H][W];
    int out_img [H][W];

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Capture output beats; framing flags must stay low whenever dout_vld is low.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.dout_vld === 1'b1) begin
                got_q.push_back('{bus.dout, bus.dout_sop, bus.dout_eop, edge_n});
            end else begin
                check("sop_idle", {31'b0, bus.dout_sop}, 32'd0);
                check("eop_idle", {31'b0, bus.dout_eop}, 32'd0);
            end
        end
    end

    // Reference 3x3 Gaussian of the bench image, centred at (r,c).
    function automatic int gauss(input int r, input int c);
        int s = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                s += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1) * img[r+dr][c+dc];
        return s / 16;
    endfunction

    task automatic fill(input int v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = v;
    endtask

    task automatic send(input int val, input bit sop, input bit eop, input bit gap);
        bus.din     = 8'(val);
        bus.din_vld = 1'b1;
        bus.din_sop = sop;
        bus.din_eop = eop;
        @(posedge clk);
        #1;
        last_in_edge = edge_n;
        bus.din_vld = 1'b0;
        bus.din_sop = 1'b0;
        bus.din_eop = 1'b0;
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Send the first npix pixels of img in raster order, queueing the expected beats.
    task automatic run_frame(input int npix, input bit gaps);
        for (int i = 0; i < npix; i++) begin
            int r = i / W;
            int c = i % W;
            send(img[r][c], i == 0, i == NP - 1, gaps);
            if (r >= 2 && c >= 2)
                exp_q.push_back('{8'(gauss(r - 1, c - 1)), (r == 2 && c == 2), (i == NP - 1), last_in_edge});
        end
    endtask

    // Drain, compare captured beats against the expected queue, map the last frame.
    task automatic check_outputs(input string name);
        int n;
        repeat (4) @(posedge clk);
        #1;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                out_img[r][c] = 999;
        check({name, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_data[%0d]", name, i), got_q[i].data, exp_q[i].data);
            check($sformatf("%s_sop[%0d]", name, i), {31'b0, got_q[i].sop}, {31'b0, exp_q[i].sop});
            check($sformatf("%s_eop[%0d]", name, i), {31'b0, got_q[i].eop}, {31'b0, exp_q[i].eop});
            // din_vld cycle ends at its edge; the output beat is seen one edge later.
            check($sformatf("%s_latency[%0d]", name, i), got_q[i].edge_no - exp_q[i].edge_no + 1, 2);
        end
        if (got_q.size() >= OW * (H - 2)) begin
            int base = got_q.size() - OW * (H - 2);
            for (int k = 0; k < OW * (H - 2); k++)
                out_img[1 + k / OW][1 + k % OW] = got_q[base + k].data;
        end
        if (got_q.size() > 0)
            check({name, "_hold"}, bus.dout, got_q[got_q.size() - 1].data);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_table(input int id);
        foreach (vecs[i])
            if (vecs[i].test == id)
                check($sformatf("t%0d_pix(%0d,%0d)", id, vecs[i].r, vecs[i].c),
                      out_img[vecs[i].r][vecs[i].c], vecs[i].exp);
    endtask

    task automatic add_vec(input int t, input int r, input int c, input int e);
        vecs.push_back('{t, r, c, e});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        // Hand-computed output pixels, indexed by window centre.
        add_vec(1, 1, 1, 100);  add_vec(1, 4, 6, 100);  add_vec(1, 2, 3, 100);
        add_vec(2, 3, 3, 63);
        add_vec(2, 2, 3, 31);   add_vec(2, 4, 3, 31);   add_vec(2, 3, 2, 31);   add_vec(2, 3, 4, 31);
        add_vec(2, 2, 2, 15);   add_vec(2, 2, 4, 15);   add_vec(2, 4, 2, 15);   add_vec(2, 4, 4, 15);
        add_vec(2, 1, 1, 0);    add_vec(2, 1, 3, 0);    add_vec(2, 4, 6, 0);    add_vec(2, 3, 6, 0);
        add_vec(3, 1, 1, 32);   add_vec(3, 1, 6, 192);  add_vec(3, 3, 4, 128);
        add_vec(6, 1, 1, 50);   add_vec(6, 4, 6, 50);
        add_vec(7, 1, 1, 77);   add_vec(7, 4, 6, 77);

        bus.din = '0; bus.din_vld = 1'b0; bus.din_sop = 1'b0; bus.din_eop = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout", bus.dout, 0);
        check("reset_vld",  {31'b0, bus.dout_vld}, 0);
        check("reset_sop",  {31'b0, bus.dout_sop}, 0);
        check("reset_eop",  {31'b0, bus.dout_eop}, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Constant frame, continuous valid
        fill(100);
        run_frame(NP, 1'b0);
        check_outputs("const");
        check_table(1);

        // Impulse at (3,3)
        fill(0);
        img[3][3] = 255;
        run_frame(NP, 1'b0);
        check_outputs("impulse");
        check_table(2);

        // Horizontal ramp
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = c * 32;
        run_frame(NP, 1'b0);
        check_outputs("ramp");
        check_table(3);

        // Constant frame with a gap after every pixel
        fill(100);
        run_frame(NP, 1'b1);
        check_outputs("gaps");
        check_table(1);

        // Frame restarted at row 3 by a new din_sop, new frame constant 50
        fill(100);
        run_frame(3 * W, 1'b0);
        fill(50);
        run_frame(NP, 1'b0);
        check_outputs("restart");
        check_table(6);

        // sop and eop on the same pixel produce nothing
        send(9, 1'b1, 1'b1, 1'b0);
        check_outputs("sop_eop");

        // Reset at pixel (4,4)
        fill(100);
        run_frame(4 * W + 4, 1'b0);
        bus.din = 8'd100; bus.din_vld = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; bus.din_vld = 1'b0;
        check("midrst_dout", bus.dout, 0);
        check("midrst_vld",  {31'b0, bus.dout_vld}, 0);
        check("midrst_sop",  {31'b0, bus.dout_sop}, 0);
        check("midrst_eop",  {31'b0, bus.dout_eop}, 0);
        got_q.delete();
        exp_q.delete();
        for (int i = 4 * W + 5; i < NP; i++)
            send(100, 1'b0, i == NP - 1, 1'b0);
        check_outputs("post_reset");
        fill(77);
        run_frame(NP, 1'b0);
        check_outputs("after_reset");
        check_table(7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
